// File: rtl/legv8_pkg.sv
// LEGv8 instruction encoder shared definitions:
// formats, field limits, opcodes and the packing function.
package legv8_pkg;

  localparam int WORD      = 64;
  localparam int INST_SIZE = 32;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_D  = 3'd2,
    FMT_B  = 3'd3,
    FMT_CB = 3'd4
  } fmt_e;

  localparam int OPC_W = 11;
  localparam int REG_W = 5;
  localparam int SH_W  = 6;

  localparam int I_IMM_W  = 12;
  localparam int D_IMM_W  = 9;
  localparam int B_IMM_W  = 26;
  localparam int CB_IMM_W = 19;

  localparam logic [WORD-1:0] I_MAX = 64'd4095;
  localparam logic signed [WORD-1:0] D_MIN  = -64'sd256;
  localparam logic signed [WORD-1:0] D_MAX  = 64'sd255;
  localparam logic signed [WORD-1:0] B_MIN  = -64'sd33554432;
  localparam logic signed [WORD-1:0] B_MAX  = 64'sd33554431;
  localparam logic signed [WORD-1:0] CB_MIN = -64'sd262144;
  localparam logic signed [WORD-1:0] CB_MAX = 64'sd262143;

  // Opcodes are left-aligned in an 11-bit field.
  localparam logic [OPC_W-1:0] OP_ADD  = 11'h458;
  localparam logic [OPC_W-1:0] OP_SUB  = 11'h658;
  localparam logic [OPC_W-1:0] OP_AND  = 11'h450;
  localparam logic [OPC_W-1:0] OP_ORR  = 11'h550;
  localparam logic [OPC_W-1:0] OP_LDUR = 11'h7C2;
  localparam logic [OPC_W-1:0] OP_STUR = 11'h7C0;
  localparam logic [OPC_W-1:0] OP_CBZ  = 11'h5A0;
  localparam logic [OPC_W-1:0] OP_B    = 11'h0A0;

  typedef struct packed {
    logic [2:0]       fmt;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic [SH_W-1:0]  shamt;
    logic [WORD-1:0]  imm;
  } enc_req_t;

  typedef struct packed {
    logic                 err;
    logic [INST_SIZE-1:0] inst;
  } enc_res_t;

  function automatic enc_res_t encode(enc_req_t r);
    enc_res_t res;
    logic signed [WORD-1:0] simm;
    logic ok;
    res = '0;
    simm = $signed(r.imm);
    ok = 1'b0;
    unique case (r.fmt)
      FMT_R: begin
        ok = 1'b1;
        res.inst = {r.opcode, r.rm, r.shamt,
                    r.rn, r.rd};
      end
      FMT_I: begin
        ok = r.imm <= I_MAX;
        res.inst = {r.opcode[10:1],
                    r.imm[I_IMM_W-1:0],
                    r.rn, r.rd};
      end
      FMT_D: begin
        ok = simm >= D_MIN && simm <= D_MAX;
        res.inst = {r.opcode,
                    r.imm[D_IMM_W-1:0],
                    2'b00, r.rn, r.rd};
      end
      FMT_B: begin
        ok = simm >= B_MIN && simm <= B_MAX;
        res.inst = {r.opcode[10:5],
                    r.imm[B_IMM_W-1:0]};
      end
      FMT_CB: begin
        ok = simm >= CB_MIN && simm <= CB_MAX;
        res.inst = {r.opcode[10:3],
                    r.imm[CB_IMM_W-1:0], r.rd};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      res.err  = 1'b1;
      res.inst = '0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head reads
// as zero when empty.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic empty, full, do_push, do_pop;

  assign empty   = count_q == '0;
  assign full    = count_q == (AW+1)'(DEPTH);
  assign do_push = push_i && (!full || pop_i);
  assign do_pop  = pop_i && !empty;
  assign count_o = count_q;
  assign data_o  = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/inst_encoder.sv
// LEGv8 instruction encoder: request register, combinational
// packing, output FIFO and pop statistics.
module inst_encoder
  import legv8_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [OPC_W-1:0]     in_opcode,
  input  logic [REG_W-1:0]     in_rd,
  input  logic [REG_W-1:0]     in_rn,
  input  logic [REG_W-1:0]     in_rm,
  input  logic [SH_W-1:0]      in_shamt,
  input  logic [WORD-1:0]      in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INST_SIZE-1:0] out_inst,
  output logic                 out_err,
  output logic [15:0]          enc_cnt,
  output logic [7:0]           err_cnt,
  input  logic                 flush
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  logic          s1_valid_q, s1_valid_d;
  enc_req_t      s1_req_q, s1_req_d;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, pop, push, can_acc;
  enc_res_t      enc_res, head;
  logic [15:0]   enc_cnt_q, enc_cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  assign out_valid = fifo_cnt != '0;
  assign fifo_full = fifo_cnt == CW'(OUT_DEPTH);
  assign pop       = out_valid && out_ready && !flush;
  // A full FIFO still takes a push when the head leaves.
  assign can_acc   = !fifo_full || pop;
  assign in_ready  = !flush && (!s1_valid_q || can_acc);
  assign push      = s1_valid_q && can_acc && !flush;
  assign enc_res   = encode(s1_req_q);
  assign out_inst  = head.inst;
  assign out_err   = head.err;
  assign enc_cnt   = enc_cnt_q;
  assign err_cnt   = err_cnt_q;

  sync_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH ($bits(enc_res_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (enc_res),
    .data_o  (head),
    .count_o (fifo_cnt)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_req_d   = s1_req_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_req_d = '{fmt: in_fmt, opcode: in_opcode,
                     rd: in_rd, rn: in_rn, rm: in_rm,
                     shamt: in_shamt, imm: in_imm};
      end
    end
  end

  always_comb begin
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (pop) begin
      enc_cnt_d = enc_cnt_q + 16'd1;
      if (head.err && err_cnt_q != 8'hFF)
        err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_req_q   <= '0;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_req_q   <= s1_req_d;
      enc_cnt_q  <= enc_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: vector table, directed corner
// sequences and a randomized queue-based reference model.
module tb_inst_encoder;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [10:0] in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rn = '0, in_rm = '0;
  logic [5:0]  in_shamt = '0;
  logic [63:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_cnt;
  logic [7:0]  err_cnt;
  logic        flush = 1'b0;

  inst_encoder #(.OUT_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_shamt(in_shamt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .enc_cnt(enc_cnt), .err_cnt(err_cnt),
    .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [2:0]  fmt;
    bit [10:0] opc;
    bit [4:0]  rd, rn, rm;
    bit [5:0]  sh;
    longint    imm;
  } req_t;

  typedef struct {
    req_t      r;
    bit [31:0] inst;
    bit        err;
  } vec_t;

  typedef struct {
    bit [31:0] inst;
    bit        err;
  } exp_t;

  exp_t   q[$];
  int     nchk = 0, nfail = 0;
  int     m_enc = 0, m_err = 0;
  bit     s_ov, s_ir, s_err, s_acc;
  bit [31:0] s_inst;
  req_t   nop;

  function automatic req_t mk(bit [2:0] f, bit [10:0] o,
                              bit [4:0] rd, bit [4:0] rn,
                              bit [4:0] rm, bit [5:0] sh,
                              longint imm);
    req_t r;
    r.fmt = f; r.opc = o; r.rd = rd; r.rn = rn;
    r.rm = rm; r.sh = sh; r.imm = imm;
    return r;
  endfunction

  // Reference packing from field weights and range limits.
  function automatic exp_t ref_enc(req_t r);
    exp_t   e;
    longint v, opc, imm;
    bit     ok;
    opc = longint'(r.opc);
    imm = r.imm;
    v = 0;
    ok = 0;
    case (r.fmt)
      3'd0: begin
        ok = 1;
        v = opc * (2**21) + longint'(r.rm) * (2**16)
          + longint'(r.sh) * (2**10)
          + longint'(r.rn) * 32 + longint'(r.rd);
      end
      3'd1: begin
        ok = imm >= 0 && imm <= 4095;
        v = (opc / 2) * (2**22) + imm * (2**10)
          + longint'(r.rn) * 32 + longint'(r.rd);
      end
      3'd2: begin
        ok = imm >= -256 && imm <= 255;
        v = opc * (2**21) + ((imm + 512) % 512) * (2**12)
          + longint'(r.rn) * 32 + longint'(r.rd);
      end
      3'd3: begin
        ok = imm >= -(2**25) && imm <= (2**25) - 1;
        v = (opc / 32) * (2**26)
          + (imm + (2**26)) % (2**26);
      end
      3'd4: begin
        ok = imm >= -(2**18) && imm <= (2**18) - 1;
        v = (opc / 8) * (2**24)
          + ((imm + (2**19)) % (2**19)) * 32
          + longint'(r.rd);
      end
      default: ok = 0;
    endcase
    e.inst = ok ? v[31:0] : 32'd0;
    e.err  = !ok;
    return e;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; outputs sampled 1ns after the
  // falling edge, scoreboard updated for the next rise.
  task automatic cyc(bit iv, req_t r, bit ordy, bit fl);
    exp_t h;
    @(negedge clk);
    in_valid = iv;  in_fmt = r.fmt;  in_opcode = r.opc;
    in_rd = r.rd;   in_rn = r.rn;    in_rm = r.rm;
    in_shamt = r.sh; in_imm = r.imm;
    out_ready = ordy; flush = fl;
    #1;
    s_ov = out_valid; s_ir = in_ready;
    s_inst = out_inst; s_err = out_err;
    s_acc = in_valid && in_ready;
    chk("enc_cnt", longint'(enc_cnt), longint'(m_enc));
    chk("err_cnt", longint'(err_cnt), longint'(m_err));
    if (out_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        h = q.pop_front();
        chk("pop_inst", longint'(out_inst), longint'(h.inst));
        chk("pop_err", longint'(out_err), longint'(h.err));
        m_enc = (m_enc + 1) % 65536;
        if (h.err && m_err < 255) m_err++;
      end
    end
    if (fl) q.delete();
    if (s_acc) q.push_back(ref_enc(r));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++)
      cyc(0, nop, 1, 0);
    cyc(0, nop, 1, 0);
    chk("drain_left", longint'(q.size()), 0);
    chk("drain_ov", longint'(s_ov), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ov", longint'(out_valid), 0);
    chk("rst_inst", longint'(out_inst), 0);
    chk("rst_err", longint'(out_err), 0);
    chk("rst_enc", longint'(enc_cnt), 0);
    chk("rst_errcnt", longint'(err_cnt), 0);
    q.delete();
    m_enc = 0; m_err = 0;
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t   vt[$];
  longint bl[16] = '{-257, -256, 255, 256, 4095, 4096, -1, 0,
                     33554431, 33554432, -33554432, -33554433,
                     262143, 262144, -262144, -262145};

  initial begin
    req_t ldur, add, cbz, bb, ra, rb, rc, rd;
    int   saved;
    nop = mk(0, 0, 0, 0, 0, 0, 0);
    ldur = mk(FMT_D, OP_LDUR, 9, 22, 0, 0, 64);
    add  = mk(FMT_R, OP_ADD, 10, 19, 9, 0, 0);
    cbz  = mk(FMT_CB, OP_CBZ, 11, 0, 0, 0, -5);
    bb   = mk(FMT_B, OP_B, 0, 0, 0, 0, -55);

    vt.push_back('{ldur, 32'hF84402C9, 0});
    vt.push_back('{add, 32'h8B09026A, 0});
    vt.push_back('{cbz, 32'hB4FFFF6B, 0});
    vt.push_back('{bb, 32'h17FFFFC9, 0});
    vt.push_back('{mk(2, OP_LDUR, 1, 2, 0, 0, 256), 0, 1});
    vt.push_back('{mk(1, 11'h489, 1, 2, 0, 0, -1), 0, 1});
    vt.push_back('{mk(1, 11'h489, 2, 1, 0, 0, 4095),
                   32'h913FFC22, 0});
    vt.push_back('{mk(1, 11'h489, 2, 1, 0, 0, 4096), 0, 1});
    vt.push_back('{mk(2, OP_STUR, 0, 0, 0, 0, -256),
                   32'hF8100000, 0});
    vt.push_back('{mk(2, OP_STUR, 0, 0, 0, 0, -257), 0, 1});
    vt.push_back('{mk(3, OP_B, 0, 0, 0, 0, 33554432), 0, 1});
    vt.push_back('{mk(3, OP_B, 0, 0, 0, 0, -33554432),
                   32'h16000000, 0});
    vt.push_back('{mk(4, 11'h5A7, 0, 0, 0, 0, 262143),
                   32'hB47FFFE0, 0});
    vt.push_back('{mk(4, OP_CBZ, 0, 0, 0, 0, -262145), 0, 1});
    vt.push_back('{mk(5, OP_ADD, 1, 2, 3, 0, 0), 0, 1});

    pulse_reset();

    // First edge after release accepts; LDUR latency.
    cyc(1, ldur, 1, 0);
    chk("ready_after_rst", longint'(s_ir), 1);
    chk("ldur_acc", longint'(s_acc), 1);
    cyc(0, nop, 1, 0);
    chk("ldur_ov_n1", longint'(s_ov), 0);
    cyc(0, nop, 1, 0);
    chk("ldur_ov_n2", longint'(s_ov), 1);
    chk("ldur_inst", longint'(s_inst), 64'hF84402C9);
    chk("ldur_err", longint'(s_err), 0);
    drain();

    // Back-to-back stream.
    cyc(1, add, 1, 0);
    chk("b2b_acc0", longint'(s_acc), 1);
    cyc(1, cbz, 1, 0);
    chk("b2b_acc1", longint'(s_acc), 1);
    cyc(1, bb, 1, 0);
    chk("b2b_acc2", longint'(s_acc), 1);
    chk("b2b_r0", longint'(s_inst), 64'h8B09026A);
    cyc(0, nop, 1, 0);
    chk("b2b_v1", longint'(s_ov), 1);
    chk("b2b_r1", longint'(s_inst), 64'hB4FFFF6B);
    cyc(0, nop, 1, 0);
    chk("b2b_v2", longint'(s_ov), 1);
    chk("b2b_r2", longint'(s_inst), 64'h17FFFFC9);
    drain();

    // Range errors counted after a fresh reset.
    pulse_reset();
    cyc(1, vt[4].r, 1, 0);
    cyc(1, vt[5].r, 1, 0);
    cyc(0, nop, 1, 0);
    chk("err_d_flag", longint'(s_err), 1);
    chk("err_d_inst", longint'(s_inst), 0);
    drain();
    chk("err_cnt_2", longint'(err_cnt), 2);

    foreach (vt[i]) begin
      cyc(1, vt[i].r, 1, 0);
      cyc(0, nop, 1, 0);
      cyc(0, nop, 1, 0);
      chk($sformatf("vec%0d_ov", i), longint'(s_ov), 1);
      chk($sformatf("vec%0d_inst", i), longint'(s_inst),
          longint'(vt[i].inst));
      chk($sformatf("vec%0d_err", i), longint'(s_err),
          longint'(vt[i].err));
    end
    drain();

    // Backpressure, hold, then push+pop while full.
    ra = add; rb = ldur; rc = cbz; rd = bb;
    cyc(1, ra, 0, 0);
    cyc(1, rb, 0, 0);
    cyc(1, rc, 0, 0);
    chk("bp_acc_c", longint'(s_acc), 1);
    cyc(1, rd, 0, 0);
    chk("bp_ready_lo", longint'(s_ir), 0);
    chk("bp_head0", longint'(s_inst), 64'h8B09026A);
    cyc(1, rd, 0, 0);
    chk("bp_ready_lo2", longint'(s_ir), 0);
    chk("bp_hold", longint'(s_inst), 64'h8B09026A);
    cyc(1, rd, 1, 0);
    chk("bp_full_pp", longint'(s_acc), 1);
    cyc(0, nop, 0, 0);
    chk("bp_full_ov", longint'(s_ov), 1);
    chk("bp_full_rdy", longint'(s_ir), 0);
    chk("bp_head1", longint'(s_inst), 64'hF84402C9);
    drain();

    // Flush with two results buffered.
    cyc(1, add, 0, 0);
    cyc(1, cbz, 0, 0);
    cyc(0, nop, 0, 0);
    saved = m_enc;
    cyc(1, bb, 0, 1);
    chk("fl_ready", longint'(s_ir), 0);
    chk("fl_acc", longint'(s_acc), 0);
    cyc(0, nop, 0, 0);
    chk("fl_ov", longint'(s_ov), 0);
    chk("fl_enc", longint'(enc_cnt), longint'(saved));
    cyc(1, ldur, 1, 0);
    cyc(0, nop, 1, 0);
    cyc(0, nop, 1, 0);
    chk("fl_next", longint'(s_inst), 64'hF84402C9);
    drain();

    // Error counter saturation.
    for (int i = 0; i < 260; i++) cyc(1, vt[4].r, 1, 0);
    drain();
    chk("err_sat", longint'(err_cnt), 255);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      req_t r;
      int   sel;
      r.fmt = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4))
                                          : 3'($urandom_range(5, 7));
      r.opc = 11'($urandom);
      r.rd = 5'($urandom); r.rn = 5'($urandom);
      r.rm = 5'($urandom); r.sh = 6'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
        0: r.imm = longint'($urandom_range(0, 600)) - 300;
        1: r.imm = bl[$urandom_range(0, 15)];
        2: r.imm = longint'(int'($urandom));
        default: r.imm = {$urandom, $urandom};
      endcase
      cyc(1'($urandom_range(0, 1)), r,
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 39) == 0));
    end
    drain();

    // Reset in the middle of traffic.
    cyc(1, cbz, 0, 0);
    cyc(1, ldur, 0, 0);
    cyc(0, nop, 0, 0);
    pulse_reset();
    cyc(1, add, 1, 0);
    chk("mid_rst_ready", longint'(s_ir), 1);
    cyc(0, nop, 1, 0);
    cyc(0, nop, 1, 0);
    chk("mid_rst_ov", longint'(s_ov), 1);
    chk("mid_rst_inst", longint'(s_inst), 64'h8B09026A);
    drain();
    chk("mid_rst_enc", longint'(enc_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
